cn_trace_monitor: RTL and testbench

- Downstream consumer of the selector-driven c/n arithmetic stage (the 10-bit `c`, `n` pair).
- Samples c/n each valid cycle and checks candidate invariants per sample.
- Buffers flagged samples in a small FIFO drained by a valid/ready port, and keeps sticky violation statistics for property-mining trace export.

---
 rtl/cn_mon_pkg.sv | 21 ++
 rtl/cn_mon_fifo.sv | 49 ++++
 rtl/cn_trace_monitor.sv | 149 ++++++++++++++
 tb/tb_cn_trace_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_mon_pkg.sv
// Shared definitions for the c/n trace monitor: FSM states, flag bit positions, default widths.
package cn_mon_pkg;

  localparam int unsigned CN_W_DEF     = 10;
  localparam int unsigned CN_DEPTH_DEF = 8;
  localparam int unsigned CN_CNT_W_DEF = 16;
  localparam int unsigned CN_FLG_N     = 4;

  localparam int unsigned FLG_BOUND = 0;
  localparam int unsigned FLG_STEP  = 1;
  localparam int unsigned FLG_NCHG  = 2;
  localparam int unsigned FLG_WRAP  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } cn_state_e;

endpackage

// File: rtl/cn_mon_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a push while full
// succeeds only if the head is popped in the same cycle, otherwise it is dropped.
module cn_mon_fifo #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] head,
  output logic          drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          pop_fire;
  logic          push_fire;

  assign valid     = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_fire  = valid && pop;
  assign push_fire = push && (!full || pop_fire);
  assign drop      = push && full && !pop_fire;

  // Head is forced to zero while empty so reset and idle outputs are clean.
  assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cn_trace_monitor.sv
// Checks c/n samples against invariants, buffers flagged samples and keeps sticky stats.
// Optional min/max tracking of c is enabled by defining CN_MON_MINMAX_EN.
module cn_trace_monitor
  import cn_mon_pkg::*;
#(
  parameter int unsigned W     = CN_W_DEF,
  parameter int unsigned DEPTH = CN_DEPTH_DEF,
  parameter int unsigned CNT_W = CN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     n,
  input  logic             record_all,
  input  logic             halt_on_viol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_c,
  output logic [W-1:0]     out_n,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] viol_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [3:0]       sticky_flags,
  output logic             halted,
  output logic [W-1:0]     min_c,
  output logic [W-1:0]     max_c
);

  localparam int unsigned DW = 2*W + CN_FLG_N;

  cn_state_e     state;
  logic [W-1:0]  c_p;
  logic [W-1:0]  n_p;
  logic [W-1:0]  c_p_inc;
  logic [3:0]    flags;
  logic          idle_sample;
  logic          run_sample;
  logic          viol;
  logic          push;
  logic          fifo_full;
  logic          fifo_drop;
  logic [DW-1:0] head;

  assign idle_sample = (state == IDLE) && in_valid;
  assign run_sample  = (state == RUN) && in_valid;
  assign c_p_inc     = c_p + W'(1);

  always_comb begin
    flags = '0;
    if (state == RUN) begin
      flags[FLG_BOUND] = (c > n);
      flags[FLG_STEP]  = (c != c_p) && (c != c_p_inc) && (c != '0);
      flags[FLG_NCHG]  = (n != n_p);
      flags[FLG_WRAP]  = (c_p == '1) && (c == '0);
    end
  end

  assign viol = run_sample && (flags != '0);
  assign push = (idle_sample && record_all) || (run_sample && ((flags != '0) || record_all));

  cn_mon_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({flags, n, c}),
    .full      (fifo_full),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (head),
    .drop      (fifo_drop)
  );

  assign out_c     = head[W-1:0];
  assign out_n     = head[2*W-1:W];
  assign out_flags = head[DW-1:2*W];

  // The IDLE->RUN step captures prev directly; PRIME is only a recovery path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_p   <= '0;
      n_p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_p   <= c;
            n_p   <= n;
            state <= RUN;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (in_valid) begin
            c_p <= c;
            n_p <= n;
            if (viol && halt_on_viol) state <= HALT;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      viol_count   <= '0;
      drop_count   <= '0;
      sticky_flags <= '0;
    end else begin
      if (viol) begin
        sticky_flags <= sticky_flags | flags;
        if (viol_count != '1) viol_count <= viol_count + CNT_W'(1);
      end
      if (fifo_drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
    end
  end

  assign halted = (state == HALT);

`ifdef CN_MON_MINMAX_EN
  logic [W-1:0] min_r;
  logic [W-1:0] max_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_r <= '1;
      max_r <= '0;
    end else if (idle_sample || run_sample) begin
      if (c < min_r) min_r <= c;
      if (c > max_r) max_r <= c;
    end
  end

  assign min_c = min_r;
  assign max_c = max_r;
`else
  assign min_c = '0;
  assign max_c = '0;
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_cn_trace_monitor.sv
// Self-checking bench for cn_trace_monitor: queue-based reference model, directed scenarios, random traffic.
module tb_cn_trace_monitor;

  localparam int W     = 10;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int unsigned MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     c = '0;
  logic [W-1:0]     n = '0;
  logic             record_all = 1'b0;
  logic             halt_on_viol = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [W-1:0]     out_c;
  logic [W-1:0]     out_n;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] viol_count;
  logic [CNT_W-1:0] drop_count;
  logic [3:0]       sticky_flags;
  logic             halted;
  logic [W-1:0]     min_c;
  logic [W-1:0]     max_c;

  cn_trace_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .c(c), .n(n),
    .record_all(record_all), .halt_on_viol(halt_on_viol),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_n(out_n), .out_flags(out_flags),
    .viol_count(viol_count), .drop_count(drop_count),
    .sticky_flags(sticky_flags), .halted(halted),
    .min_c(min_c), .max_c(max_c)
  );

  typedef struct {
    int unsigned c;
    int unsigned n;
    int unsigned f;
  } ent_t;

  ent_t        q[$];
  int          m_mode = 0;   // 0 idle, 1 run, 2 halt
  int unsigned m_cp = 0, m_np = 0;
  int unsigned m_viol = 0, m_drop = 0, m_sticky = 0;
  int unsigned m_min = MAXV, m_max = 0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference: what the monitor must hold after the edge that consumes these inputs.
  function automatic void model_step(bit r, bit iv, int unsigned cc, int unsigned nn,
                                     bit ra, bit hov, bit ordy);
    int unsigned f;
    bit do_push;
    bit pop;
    if (r) begin
      q.delete();
      m_mode = 0; m_cp = 0; m_np = 0;
      m_viol = 0; m_drop = 0; m_sticky = 0;
      m_min = MAXV; m_max = 0;
      return;
    end
    pop = (q.size() > 0) && ordy;
    do_push = 0;
    f = 0;
    if (iv && m_mode == 0) begin
      do_push = ra;
      m_mode = 1;
      m_cp = cc; m_np = nn;
      if (cc < m_min) m_min = cc;
      if (cc > m_max) m_max = cc;
    end else if (iv && m_mode == 1) begin
      if (cc > nn) f += 1;
      if (cc != m_cp && cc != ((m_cp + 1) % (MAXV + 1)) && cc != 0) f += 2;
      if (nn != m_np) f += 4;
      if (m_cp == MAXV && cc == 0) f += 8;
      do_push = (f != 0) || ra;
      if (f != 0) begin
        if (m_viol < 65535) m_viol++;
        m_sticky = m_sticky | f;
        if (hov) m_mode = 2;
      end
      m_cp = cc; m_np = nn;
      if (cc < m_min) m_min = cc;
      if (cc > m_max) m_max = cc;
    end
    if (pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back('{c: cc, n: nn, f: f});
      else if (m_drop < 65535) m_drop++;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        chk("out_c", out_c, q[0].c);
        chk("out_n", out_n, q[0].n);
        chk("out_flags", out_flags, q[0].f);
      end
      chk("viol_count", viol_count, m_viol);
      chk("drop_count", drop_count, m_drop);
      chk("sticky_flags", sticky_flags, m_sticky);
      chk("halted", halted, (m_mode == 2) ? 1 : 0);
`ifdef CN_MON_MINMAX_EN
      chk("min_c", min_c, m_min);
      chk("max_c", max_c, m_max);
`else
      chk("min_c", min_c, 0);
      chk("max_c", max_c, 0);
`endif
    end
  end

  task automatic cyc(bit r, bit iv, int unsigned cc, int unsigned nn, bit ra, bit hov, bit ordy);
    model_step(r, iv, cc, nn, ra, hov, ordy);
    rst = r; in_valid = iv;
    c = cc[W-1:0]; n = nn[W-1:0];
    record_all = ra; halt_on_viol = hov; out_ready = ordy;
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned lastc, nbase, cc, nn;
    bit r, iv, ra, hov, ordy;

    // Monotonic stream with record_all off: nothing queued, no violations
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_viol", viol_count, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, i, 100, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mono_empty", out_valid, 0);
    chk("mono_viol", viol_count, 0);
    chk("mono_sticky", sticky_flags, 0);

    // record_all with immediate drain
    do_reset();
    cyc(0, 1, 0, 100, 1, 0, 1);
    chk("ra_first_valid", out_valid, 1);
    chk("ra_first_c", out_c, 0);
    chk("ra_first_flags", out_flags, 0);
    cyc(0, 1, 1, 100, 1, 0, 1);
    cyc(0, 1, 2, 100, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 1);
    chk("ra_drained", out_valid, 0);

    // STEP violation, then halt on violation
    do_reset();
    cyc(0, 1, 5, 100, 0, 0, 0);
    cyc(0, 1, 9, 100, 0, 0, 0);
    chk("step_valid", out_valid, 1);
    chk("step_c", out_c, 9);
    chk("step_flags", out_flags, 4'b0010);
    chk("step_viol", viol_count, 1);
    do_reset();
    cyc(0, 1, 5, 100, 0, 1, 0);
    cyc(0, 1, 9, 100, 0, 1, 0);
    chk("halt_set", halted, 1);
    cyc(0, 1, 10, 100, 0, 1, 0);
    cyc(0, 1, 50, 20, 0, 1, 0);
    chk("halt_viol", viol_count, 1);
    chk("halt_sticky", sticky_flags, 4'b0010);
    chk("halt_stay", halted, 1);

    // WRAP and BOUND
    do_reset();
    cyc(0, 1, 1023, 1023, 0, 0, 0);
    cyc(0, 1, 0, 1023, 0, 0, 0);
    chk("wrap_flags", out_flags, 4'b1000);
    chk("wrap_c", out_c, 0);
    do_reset();
    cyc(0, 1, 50, 20, 0, 0, 0);
    cyc(0, 1, 50, 20, 0, 0, 0);
    chk("bound_flags", out_flags, 4'b0001);

    // Backpressure: 12 pushes into 8 slots
    do_reset();
    for (int i = 0; i < 12; i++) cyc(0, 1, i, 100, 1, 0, 0);
    chk("bp_drop", drop_count, 4);
    chk("bp_head", out_c, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("bp_head_stable", out_c, 0);
    chk("bp_valid_held", out_valid, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 0, 1);
    chk("bp_drained", out_valid, 0);

    // Reset mid-stream with 5 entries queued
    do_reset();
    cyc(0, 1, 0, 100, 1, 0, 0);
    cyc(0, 1, 1, 100, 1, 0, 0);
    cyc(0, 1, 2, 100, 1, 0, 0);
    cyc(0, 1, 7, 100, 1, 0, 0);
    cyc(0, 1, 8, 100, 1, 0, 0);
    chk("mid_viol_pre", viol_count, 1);
    do_reset();
    chk("mid_valid", out_valid, 0);
    chk("mid_viol", viol_count, 0);
    chk("mid_sticky", sticky_flags, 0);
    chk("mid_halted", halted, 0);
    cyc(0, 1, 7, 3, 1, 0, 0);
    chk("mid_prime_valid", out_valid, 1);
    chk("mid_prime_c", out_c, 7);
    chk("mid_prime_flags", out_flags, 0);
    chk("mid_prime_viol", viol_count, 0);

    // Random traffic
    do_reset();
    lastc = 0;
    nbase = 500;
    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      r   = ($urandom_range(0, 149) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      k   = $urandom_range(0, 9);
      if (k < 4)       cc = lastc;
      else if (k < 8)  cc = (lastc + 1) % (MAXV + 1);
      else if (k == 8) cc = $urandom_range(0, MAXV);
      else             cc = ($urandom_range(0, 1) == 0) ? 0 : MAXV;
      if ($urandom_range(0, 39) == 0) nbase = $urandom_range(0, MAXV);
      nn   = ($urandom_range(0, 29) == 0) ? $urandom_range(0, MAXV) : nbase;
      ra   = ($urandom_range(0, 3) == 0);
      hov  = ($urandom_range(0, 399) == 0);
      ordy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
      if (iv) lastc = cc;
      cyc(r, iv, cc, nn, ra, hov, ordy);
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("final_drained", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
